// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared definitions for the data memory unit.
// Holds the RV32 load/store funct3 codes, the fault codes reported with a
// response, the FSM state type, the latched request record and the
// load-data extension helper.
`timescale 1ns/1ps
package riscv_mem_pkg;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Fault codes
  localparam logic [1:0] FAULT_NONE       = 2'd0;
  localparam logic [1:0] FAULT_MISALIGNED = 2'd1;
  localparam logic [1:0] FAULT_RANGE      = 2'd2;
  localparam logic [1:0] FAULT_SIZE       = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] write_data;
  } mem_req_t;

  // Pick the addressed byte/half out of a word and extend it per funct3.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  offset);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (offset)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    h = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   r = {{24{b[7]}}, b};
      F3_LH:   r = {{16{h[15]}}, h};
      F3_LW:   r = word;
      F3_LBU:  r = {24'h000000, b};
      F3_LHU:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dm_byte_lane_ram.sv
// dm_byte_lane_ram: DEPTH_WORDS x 32-bit storage, byte-lane writes.
// Ports:
//   clock      - write clock
//   addr       - word index (shared by read and write)
//   we         - write strobe
//   be         - per-byte lane enables, bit i -> bits [8i+7:8i]
//   write_data - lane-aligned write data
//   read_data  - asynchronous read of the word at addr
// Contents are not reset.
`timescale 1ns/1ps
module dm_byte_lane_ram #(
  parameter int DEPTH_WORDS = 64,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clock,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   write_data,
  output logic [31:0]   read_data
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
  end

  assign read_data = mem[addr];

endmodule

// File: rtl/data_memory_unit.sv
// data_memory_unit: handshaked RV32 load/store data memory.
// Ports:
//   clock, reset_n          - clock, synchronous active-low reset
//   req_valid/req_ready     - request handshake
//   req_write, req_funct3   - store/load and RV32 size/sign code
//   req_address             - byte address
//   req_write_data          - right-aligned store data
//   resp_valid/resp_ready   - response handshake
//   resp_read_data          - extended load data (0 for stores/faults)
//   resp_fault(_code)       - rejection flag and reason
// A request is latched in IDLE, optionally delayed in WAIT, and completed in
// RESP. The first RESP edge commits the store / captures the load data and
// raises resp_valid; the fields are then held until the handshake.
`timescale 1ns/1ps
module data_memory_unit
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_read_data,
  output logic        resp_fault,
  output logic [1:0]  resp_fault_code
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t      state;
  logic [3:0]  count;
  mem_req_t    req_q;
  logic [1:0]  fault_code;
  logic [3:0]  lane_be;
  logic [31:0] lane_data;
  logic [31:0] ram_rdata;
  logic        ram_we;

  // Gated with reset so the unit never advertises readiness while held in reset.
  assign req_ready = (state == IDLE) && reset_n;

  // Fault classification of the latched request, highest priority first.
  always_comb begin
    logic illegal;
    logic misaligned;
    logic out_range;
    fault_code = FAULT_NONE;
    if (req_q.write) begin
      illegal = !(req_q.funct3 inside {F3_SB, F3_SH, F3_SW});
    end else begin
      illegal = !(req_q.funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    end
    misaligned = ((req_q.funct3[1:0] == 2'b01) && req_q.address[0]) ||
                 ((req_q.funct3[1:0] == 2'b10) && (req_q.address[1:0] != 2'b00));
    out_range  = req_q.address[31:2] >= 30'(DEPTH_WORDS);
    if (illegal) begin
      fault_code = FAULT_SIZE;
    end else if (misaligned) begin
      fault_code = FAULT_MISALIGNED;
    end else if (out_range) begin
      fault_code = FAULT_RANGE;
    end else begin
      fault_code = FAULT_NONE;
    end
  end

  // Store lane steering: replicate the data and enable only addressed lanes.
  always_comb begin
    lane_be   = 4'b0000;
    lane_data = req_q.write_data;
    case (req_q.funct3)
      F3_SB: begin
        lane_be   = 4'b0001 << req_q.address[1:0];
        lane_data = {4{req_q.write_data[7:0]}};
      end
      F3_SH: begin
        lane_be   = req_q.address[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{req_q.write_data[15:0]}};
      end
      F3_SW: begin
        lane_be   = 4'b1111;
        lane_data = req_q.write_data;
      end
      default: begin
        lane_be   = 4'b0000;
        lane_data = req_q.write_data;
      end
    endcase
  end

  // The commit edge is the first RESP cycle, before resp_valid is raised.
  assign ram_we = (state == RESP) && !resp_valid && req_q.write &&
                  (fault_code == FAULT_NONE);

  dm_byte_lane_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clock      (clock),
    .addr       (req_q.address[AW+1:2]),
    .we         (ram_we),
    .be         (lane_be),
    .write_data (lane_data),
    .read_data  (ram_rdata)
  );

  // Request/response FSM with registered response fields.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= IDLE;
      count           <= 4'd0;
      req_q           <= '0;
      resp_valid      <= 1'b0;
      resp_read_data  <= 32'h0000_0000;
      resp_fault      <= 1'b0;
      resp_fault_code <= FAULT_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_q <= '{write: req_write, funct3: req_funct3,
                       address: req_address, write_data: req_write_data};
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
              count <= 4'(WAIT_CYCLES - 1);
            end else begin
              state <= RESP;
            end
          end
        end
        WAIT: begin
          if (count == 4'd0) state <= RESP;
          else               count <= count - 4'd1;
        end
        RESP: begin
          if (!resp_valid) begin
            resp_valid      <= 1'b1;
            resp_fault      <= (fault_code != FAULT_NONE);
            resp_fault_code <= fault_code;
            resp_read_data  <= (req_q.write || (fault_code != FAULT_NONE)) ?
                               32'h0000_0000 :
                               load_extend(ram_rdata, req_q.funct3, req_q.address[1:0]);
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit: one instance with no wait states and
// one with three, exercised by per-feature test tasks.
`timescale 1ns/1ps
module tb_data_memory_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Instance A: WAIT_CYCLES = 0
  logic        a_reset_n, a_req_valid, a_req_ready, a_req_write;
  logic [2:0]  a_req_funct3;
  logic [31:0] a_req_address, a_req_write_data, a_resp_read_data;
  logic        a_resp_valid, a_resp_ready, a_resp_fault;
  logic [1:0]  a_resp_fault_code;
  // Instance B: WAIT_CYCLES = 3
  logic        b_reset_n, b_req_valid, b_req_ready, b_req_write;
  logic [2:0]  b_req_funct3;
  logic [31:0] b_req_address, b_req_write_data, b_resp_read_data;
  logic        b_resp_valid, b_resp_ready, b_resp_fault;
  logic [1:0]  b_resp_fault_code;

  data_memory_unit #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut_a (
    .clock(clock), .reset_n(a_reset_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_write(a_req_write), .req_funct3(a_req_funct3), .req_address(a_req_address),
    .req_write_data(a_req_write_data), .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_read_data(a_resp_read_data), .resp_fault(a_resp_fault),
    .resp_fault_code(a_resp_fault_code));

  data_memory_unit #(.DEPTH_WORDS(64), .WAIT_CYCLES(3)) dut_b (
    .clock(clock), .reset_n(b_reset_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_funct3(b_req_funct3), .req_address(b_req_address),
    .req_write_data(b_req_write_data), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_read_data(b_resp_read_data), .resp_fault(b_resp_fault),
    .resp_fault_code(b_resp_fault_code));

  task automatic drive(input int sel, input logic v, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (sel == 0) begin
      a_req_valid = v; a_req_write = wr; a_req_funct3 = f3; a_req_address = addr; a_req_write_data = wd;
    end else begin
      b_req_valid = v; b_req_write = wr; b_req_funct3 = f3; b_req_address = addr; b_req_write_data = wd;
    end
  endtask

  task automatic set_rr(input int sel, input logic v);
    if (sel == 0) a_resp_ready = v;
    else          b_resp_ready = v;
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? a_req_ready : b_req_ready;
  endfunction

  function automatic logic get_valid(input int sel);
    return (sel == 0) ? a_resp_valid : b_resp_valid;
  endfunction

  // Issue one request, measure cycles from accept edge to resp_valid, capture
  // the response, and optionally complete the handshake.
  task automatic issue(input int sel, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input bit early, input bit finish,
                       output int lat, output logic [31:0] data,
                       output logic fault, output logic [1:0] code);
    int n;
    @(negedge clock);
    n = 0;
    while (!get_ready(sel) && n < 50) begin @(negedge clock); n++; end
    drive(sel, 1'b1, wr, f3, addr, wd);
    if (early) set_rr(sel, 1'b1);
    @(posedge clock); #1;
    drive(sel, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); @(negedge clock);
      if (get_valid(sel)) begin lat = i; break; end
    end
    data  = (sel == 0) ? a_resp_read_data  : b_resp_read_data;
    fault = (sel == 0) ? a_resp_fault      : b_resp_fault;
    code  = (sel == 0) ? a_resp_fault_code : b_resp_fault_code;
    if (finish || lat < 0) begin
      set_rr(sel, 1'b1);
      @(posedge clock); #1;
      set_rr(sel, 1'b0);
    end
  endtask

  task automatic test_reset;
    a_reset_n = 1'b0; b_reset_n = 1'b0;
    a_resp_ready = 1'b0; b_resp_ready = 1'b0;
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) @(negedge clock);
    total++; if (a_req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0", a_req_ready); end
    total++; if (a_resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", a_resp_valid); end
    total++; if (a_resp_read_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", a_resp_read_data); end
    total++; if ({a_resp_fault, a_resp_fault_code} !== 3'b000) begin bad++; $display("FAIL reset_fault got=%b%b exp=000", a_resp_fault, a_resp_fault_code); end
    total++; if (b_req_ready !== 1'b0) begin bad++; $display("FAIL reset_b_req_ready got=%b exp=0", b_req_ready); end
    a_reset_n = 1'b1; b_reset_n = 1'b1;
    @(negedge clock);
    total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", a_req_ready); end
    total++; if (b_req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_b_ready got=%b exp=1", b_req_ready); end
  endtask

  task automatic test_store_load;
    int lat; logic [31:0] d; logic f; logic [1:0] c;
    issue(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, lat, d, f, c);
    total++; if (lat !== 1) begin bad++; $display("FAIL sw_latency got=%0d exp=1", lat); end
    total++; if ({f, c, d} !== 35'h0) begin bad++; $display("FAIL sw_resp got=%b %0d %h exp=0 0 0", f, c, d); end
    issue(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b1, lat, d, f, c);
    total++; if (lat !== 1) begin bad++; $display("FAIL lw_latency got=%0d exp=1", lat); end
    total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", d); end
    total++; if (f !== 1'b0) begin bad++; $display("FAIL lw_fault got=%b exp=0", f); end
  endtask

  task automatic test_byte_half;
    int lat; logic [31:0] d; logic f; logic [1:0] c;
    issue(0, 1'b1, 3'b000, 32'h13, 32'h00000080, 1'b0, 1'b1, lat, d, f, c);
    issue(0, 1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 1'b1, lat, d, f, c);
    total++; if (d !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_sign got=%h exp=ffffff80", d); end
    issue(0, 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 1'b1, lat, d, f, c);
    total++; if (d !== 32'h00000080) begin bad++; $display("FAIL lbu_zero got=%h exp=00000080", d); end
    issue(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b1, lat, d, f, c);
    total++; if (d !== 32'h80ADBEEF) begin bad++; $display("FAIL lw_after_sb got=%h exp=80adbeef", d); end
    issue(0, 1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 1'b1, lat, d, f, c);
    total++; if (d !== 32'hFFFF80AD) begin bad++; $display("FAIL lh_sign got=%h exp=ffff80ad", d); end
    issue(0, 1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 1'b1, lat, d, f, c);
    total++; if (d !== 32'h000080AD) begin bad++; $display("FAIL lhu_zero got=%h exp=000080ad", d); end
    issue(0, 1'b1, 3'b001, 32'h12, 32'h0000A5C3, 1'b0, 1'b1, lat, d, f, c);
    issue(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b1, lat, d, f, c);
    total++; if (d !== 32'hA5C3BEEF) begin bad++; $display("FAIL lw_after_sh got=%h exp=a5c3beef", d); end
  endtask

  task automatic test_faults;
    int lat; logic [31:0] d; logic f; logic [1:0] c;
    issue(0, 1'b0, 3'b001, 32'h11, 32'h0, 1'b0, 1'b1, lat, d, f, c);
    total++; if ({f, c, d} !== {1'b1, 2'd1, 32'h0}) begin bad++; $display("FAIL lh_misaligned got=%b %0d %h exp=1 1 0", f, c, d); end
    issue(0, 1'b1, 3'b010, 32'h0, 32'h55AA33CC, 1'b0, 1'b1, lat, d, f, c);
    issue(0, 1'b1, 3'b010, 32'h100, 32'h11111111, 1'b0, 1'b1, lat, d, f, c);
    total++; if ({f, c} !== {1'b1, 2'd2}) begin bad++; $display("FAIL sw_range got=%b %0d exp=1 2", f, c); end
    issue(0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b1, lat, d, f, c);
    total++; if (d !== 32'h55AA33CC) begin bad++; $display("FAIL range_no_write got=%h exp=55aa33cc", d); end
    issue(0, 1'b0, 3'b011, 32'h0, 32'h0, 1'b0, 1'b1, lat, d, f, c);
    total++; if ({f, c, d} !== {1'b1, 2'd3, 32'h0}) begin bad++; $display("FAIL load_illegal got=%b %0d %h exp=1 3 0", f, c, d); end
    issue(0, 1'b1, 3'b100, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1, lat, d, f, c);
    total++; if ({f, c} !== {1'b1, 2'd3}) begin bad++; $display("FAIL store_illegal got=%b %0d exp=1 3", f, c); end
    issue(0, 1'b0, 3'b010, 32'h101, 32'h0, 1'b0, 1'b1, lat, d, f, c);
    total++; if (c !== 2'd1) begin bad++; $display("FAIL prio_misaligned got=%0d exp=1", c); end
    issue(0, 1'b0, 3'b111, 32'h101, 32'h0, 1'b0, 1'b1, lat, d, f, c);
    total++; if (c !== 2'd3) begin bad++; $display("FAIL prio_illegal got=%0d exp=3", c); end
    issue(0, 1'b1, 3'b010, 32'hFC, 32'h0BADF00D, 1'b0, 1'b1, lat, d, f, c);
    issue(0, 1'b0, 3'b010, 32'hFC, 32'h0, 1'b0, 1'b1, lat, d, f, c);
    total++; if ({f, d} !== {1'b0, 32'h0BADF00D}) begin bad++; $display("FAIL last_word got=%b %h exp=0 0badf00d", f, d); end
    issue(0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b1, lat, d, f, c);
    total++; if (d !== 32'h55AA33CC) begin bad++; $display("FAIL store_illegal_no_write got=%h exp=55aa33cc", d); end
  endtask

  task automatic test_wait_hold;
    int lat; logic [31:0] d; logic f; logic [1:0] c;
    issue(1, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1'b0, 1'b1, lat, d, f, c);
    total++; if (lat !== 4) begin bad++; $display("FAIL wait_sw_latency got=%0d exp=4", lat); end
    issue(1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 1'b0, lat, d, f, c);
    total++; if (lat !== 4) begin bad++; $display("FAIL wait_lw_latency got=%0d exp=4", lat); end
    total++; if (d !== 32'hCAFEF00D) begin bad++; $display("FAIL wait_lw_data got=%h exp=cafef00d", d); end
    drive(1, 1'b1, 1'b1, 3'b010, 32'h20, 32'hBAD0BAD0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); @(negedge clock);
      total++;
      if (b_resp_valid !== 1'b1 || b_resp_read_data !== 32'hCAFEF00D || b_req_ready !== 1'b0) begin
        bad++; $display("FAIL hold_stable cyc=%0d got v=%b d=%h rdy=%b exp v=1 d=cafef00d rdy=0",
                        i, b_resp_valid, b_resp_read_data, b_req_ready);
      end
    end
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    b_resp_ready = 1'b1;
    @(posedge clock); #1;
    b_resp_ready = 1'b0;
    @(negedge clock);
    total++; if ({b_req_ready, b_resp_valid} !== 2'b10) begin bad++; $display("FAIL idle_after_hs got=%b%b exp=10", b_req_ready, b_resp_valid); end
    issue(1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 1'b1, lat, d, f, c);
    total++; if (lat !== 4 || d !== 32'hCAFEF00D) begin bad++; $display("FAIL early_ready got lat=%0d d=%h exp lat=4 d=cafef00d", lat, d); end
  endtask

  task automatic test_reset_in_wait;
    int lat; logic [31:0] d; logic f; logic [1:0] c;
    @(negedge clock);
    drive(1, 1'b1, 1'b1, 3'b010, 32'h20, 32'h12345678);
    @(posedge clock); #1;
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clock);
    total++; if (b_req_ready !== 1'b0) begin bad++; $display("FAIL in_wait_ready got=%b exp=0", b_req_ready); end
    b_reset_n = 1'b0;
    @(negedge clock);
    total++;
    if ({b_req_ready, b_resp_valid, b_resp_fault, b_resp_fault_code} !== 5'b0 || b_resp_read_data !== 32'h0) begin
      bad++; $display("FAIL reset_in_wait got rdy=%b v=%b f=%b c=%0d d=%h exp all 0",
                      b_req_ready, b_resp_valid, b_resp_fault, b_resp_fault_code, b_resp_read_data);
    end
    @(negedge clock);
    b_reset_n = 1'b1;
    issue(1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 1'b1, lat, d, f, c);
    total++; if (d !== 32'hCAFEF00D) begin bad++; $display("FAIL dropped_store got=%h exp=cafef00d", d); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_half();
    test_faults();
    test_wait_hold();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
